// File: rtl/sar_controller_if.sv
// Bus between the SAR sequencer and its surroundings.
// Signals:
//   start     - conversion request from the requester
//   cmp_in    - comparator decision from the adc stage (1 = vin >= dac_code)
//   dac_code  - trial code to adc.analogcompare
//   result    - last completed conversion code
//   busy      - conversion in progress
//   done      - one-cycle completion strobe
//   overrange - result is all ones
// Modports: master = requester/adc side, slave = sar_controller.
interface sar_controller_if #(
    parameter int WIDTH = 7
);
    logic             start;
    logic             cmp_in;
    logic [WIDTH-1:0] dac_code;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             overrange;

    modport master (
        output start, cmp_in,
        input  dac_code, result, busy, done, overrange
    );

    modport slave (
        input  start, cmp_in,
        output dac_code, result, busy, done, overrange
    );
endinterface

// File: rtl/sar_controller.sv
// Successive-approximation sequencer for the comparator-based ADC stage.
// Resolves one bit per step, MSB first. Each step drives a trial code on
// dac_code, waits SETTLE_CYCLES cycles and then takes the comparator decision.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, priority over everything
//   bus  - sar_controller_if slave: start/cmp_in in; dac_code, result,
//          busy, done, overrange out (all registered)
module sar_controller #(
    parameter int WIDTH         = 7,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    sar_controller_if.slave bus
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Current code with the bit under test resolved by the comparator.
    logic [WIDTH-1:0] resolved;
    // Resolved code with the next lower bit set as the next trial.
    logic [WIDTH-1:0] next_trial;

    always_comb begin
        resolved = dac_q;
        if (!bus.cmp_in) begin
            resolved[bit_idx_q] = 1'b0;
        end
        next_trial = resolved;
        if (bit_idx_q != '0) begin
            next_trial[bit_idx_q - IDX_W'(1)] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        dac_d     = dac_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dac_d     = {1'b1, {(WIDTH-1){1'b0}}};
                    bit_idx_d = IDX_W'(WIDTH - 1);
                    cnt_d     = CNT_W'(SETTLE_CYCLES);
                    busy_d    = 1'b1;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bit_idx_q != '0) begin
                    dac_d     = next_trial;
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                    cnt_d     = CNT_W'(SETTLE_CYCLES);
                end else begin
                    dac_d    = resolved;
                    result_d = resolved;
                    ovr_d    = &resolved;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here: no queueing.
                done_d  = 1'b0;
                busy_d  = 1'b0;
                dac_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dac_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dac_q     <= dac_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.dac_code  = dac_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overrange = ovr_q;
endmodule
